// File: rtl/hdmi_video_source_if.sv
// hdmi_video_source_if: frame-buffer read port.
// Strobe and address out, fixed-latency data back.
interface hdmi_video_source_if #(
   parameter int ADDR_W = 19
) ();
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [11:0]       rd_data;

   modport master (
      output rd_en,
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  rd_en,
      input  rd_addr,
      output rd_data
   );
endinterface

// File: rtl/hdmi_video_source.sv
// hdmi_video_source: raster timing, frame-buffer fetch and
// colour-bar test pattern, aligned to the HDMI top.
module hdmi_video_source #(
   parameter int   H_ACTIVE   = 640,
   parameter int   H_FP       = 16,
   parameter int   H_SYNC     = 96,
   parameter int   H_BP       = 48,
   parameter int   V_ACTIVE   = 480,
   parameter int   V_FP       = 10,
   parameter int   V_SYNC     = 2,
   parameter int   V_BP       = 33,
   parameter logic SYNC_POL   = 1'b0,
   parameter int   RD_LATENCY = 2,
   parameter int   ADDR_W     = 19
) (
   input  logic                 i_p_clk,
   input  logic                 i_resetn,
   input  logic                 i_pattern_en,
   hdmi_video_source_if.master  fb,
   output logic [11:0]          o_pixel,
   output logic                 o_hsync,
   output logic                 o_vsync,
   output logic                 o_active_area,
   output logic                 o_frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_END  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] BAR_WL = HW'(H_ACTIVE / 8);
   localparam logic [VW-1:0] V_END  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   // Timing and pattern data travelling alongside the read.
   typedef struct packed {
      logic        act;
      logic        hs;
      logic        vs;
      logic        fs;
      logic        pat;
      logic [11:0] pix;
   } tap_t;

   logic [HW-1:0]     h;
   logic [VW-1:0]     v;
   logic [ADDR_W-1:0] addr;
   logic              mode;
   logic              h_end;
   logic              frame_wrap;
   logic              raw_active;
   logic [HW-1:0]     bar_q;
   logic [11:0]       pat_pix;
   tap_t              cur;
   tap_t              tail;
   tap_t              pipe [RD_LATENCY+1];
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;

   function automatic logic [11:0] bar_color(input logic [2:0] idx);
      logic [11:0] c;
      unique case (idx)
         3'd0: c = 12'hFFF;
         3'd1: c = 12'hFF0;
         3'd2: c = 12'h0FF;
         3'd3: c = 12'h0F0;
         3'd4: c = 12'hF0F;
         3'd5: c = 12'hF00;
         3'd6: c = 12'h00F;
         default: c = 12'h000;
      endcase
      return c;
   endfunction

   assign h_end      = (h == H_END);
   assign frame_wrap = h_end && (v == V_END);
   assign raw_active = (h < H_ACT) && (v < V_ACT);
   assign bar_q      = h / BAR_WL;
   assign pat_pix    = (bar_q < HW'(8)) ? bar_color(bar_q[2:0]) : 12'h000;

   // Counter-stage snapshot entering the delay line.
   always_comb begin
      cur     = '0;
      cur.act = raw_active;
      cur.hs  = (h >= HS_BEG) && (h < HS_END);
      cur.vs  = (v >= VS_BEG) && (v < VS_END);
      cur.fs  = (h == '0) && (v == '0);
      cur.pat = mode;
      cur.pix = pat_pix;
   end

   assign tail       = pipe[RD_LATENCY];
   assign fb.rd_en   = rd_en;
   assign fb.rd_addr = rd_addr;

   // Raster and address counters; pattern mode latched at frame wrap.
   always_ff @(posedge i_p_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         h    <= '0;
         v    <= '0;
         addr <= '0;
         mode <= 1'b0;
      end else begin
         if (h_end) begin
            h <= '0;
            v <= (v == V_END) ? '0 : v + VW'(1);
         end else begin
            h <= h + HW'(1);
         end
         if (frame_wrap) begin
            addr <= '0;
            mode <= i_pattern_en;
         end else if (raw_active) begin
            addr <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
         end
      end
   end

   // Read strobe and address, silenced while the pattern is shown.
   always_ff @(posedge i_p_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         rd_en   <= 1'b0;
         rd_addr <= '0;
      end else begin
         rd_en   <= raw_active && !mode;
         rd_addr <= mode ? '0 : addr;
      end
   end

   // Delay line matching the read latency of the frame buffer.
   always_ff @(posedge i_p_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i <= RD_LATENCY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= cur;
         for (int i = 1; i <= RD_LATENCY; i++) pipe[i] <= pipe[i-1];
      end
   end

   // Output register: pixel select, blanking and sync polarity.
   always_ff @(posedge i_p_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         o_pixel       <= 12'h000;
         o_hsync       <= ~SYNC_POL;
         o_vsync       <= ~SYNC_POL;
         o_active_area <= 1'b0;
         o_frame_start <= 1'b0;
      end else begin
         o_hsync       <= tail.hs ? SYNC_POL : ~SYNC_POL;
         o_vsync       <= tail.vs ? SYNC_POL : ~SYNC_POL;
         o_active_area <= tail.act;
         o_frame_start <= tail.fs;
         if (!tail.act)    o_pixel <= 12'h000;
         else if (tail.pat) o_pixel <= tail.pix;
         else              o_pixel <= fb.rd_data;
      end
   end
endmodule

// File: tb/tb_hdmi_video_source.sv
// tb_hdmi_video_source: four instances (read latency 1..4) on a
// shrunk raster, scoreboard against a raster model plus vectors.
module tb_hdmi_video_source;
   localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
   localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam int BW = HA / 8;
   localparam int AW = 19;
   localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                        12'hF0F, 12'hF00, 12'h00F, 12'h000};

   typedef struct packed {
      logic          valid;
      logic          mode;
      logic [7:0]    h;
      logic [7:0]    v;
      logic [11:0]   pix;
      logic          hs;
      logic          vs;
      logic          act;
      logic          fs;
      logic          rd_en;
      logic [AW-1:0] rd_addr;
   } exp_t;

   typedef struct {
      int          h;
      int          v;
      logic [11:0] pix;
      logic        hs;
      logic        vs;
      logic        act;
   } vec_t;

   logic clk;
   logic rst_n;
   logic pattern_en;
   int   m_h, m_v;
   logic m_mode;
   int   nchk, fails;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      nchk++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h (model h=%0d v=%0d)",
                  nm, got, want, m_h, m_v);
      end
   endtask

   function automatic exp_t idle_exp();
      exp_t r;
      r    = '0;
      r.hs = 1'b1;
      r.vs = 1'b1;
      return r;
   endfunction

   function automatic exp_t model_exp();
      exp_t r;
      int   a;
      r       = idle_exp();
      r.valid = 1'b1;
      r.mode  = m_mode;
      r.h     = 8'(m_h);
      r.v     = 8'(m_v);
      r.act   = (m_h < HA) && (m_v < VA);
      a       = m_v * HA + m_h;
      if (r.act) r.pix = m_mode ? BARS[m_h / BW] : 12'(a);
      r.hs    = !(m_h >= HA + HFP && m_h < HA + HFP + HS);
      r.vs    = !(m_v >= VA + VFP && m_v < VA + VFP + VS);
      r.fs    = (m_h == 0) && (m_v == 0);
      r.rd_en = r.act && !m_mode;
      r.rd_addr = m_mode ? '0 : AW'(a);
      return r;
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference raster: counters and per-frame mode latch.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_h <= 0;
         m_v <= 0;
         m_mode <= 1'b0;
      end else if (m_h == HT - 1) begin
         m_h <= 0;
         if (m_v == VT - 1) begin
            m_v <= 0;
            m_mode <= pattern_en;
         end else begin
            m_v <= m_v + 1;
         end
      end else begin
         m_h <= m_h + 1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : lane
      localparam int L = g + 1;
      logic [11:0]   pix;
      logic          hs, vs, act, fs, rd_en;
      logic [AW-1:0] rd_addr;
      logic [AW:0]   mq [L];
      logic          tag_valid, tag_mode;
      logic [7:0]    tag_h, tag_v;
      logic [17:0]   snap;
      exp_t          q[$];
      exp_t          prev, e, f;

      hdmi_video_source_if #(.ADDR_W(AW)) fb ();

      hdmi_video_source #(
         .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
         .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
         .SYNC_POL(1'b0), .RD_LATENCY(L), .ADDR_W(AW)
      ) dut (
         .i_p_clk(clk),
         .i_resetn(rst_n),
         .i_pattern_en(pattern_en),
         .fb(fb),
         .o_pixel(pix),
         .o_hsync(hs),
         .o_vsync(vs),
         .o_active_area(act),
         .o_frame_start(fs)
      );

      assign rd_en   = fb.rd_en;
      assign rd_addr = fb.rd_addr;
      assign fb.rd_data = mq[L-1][AW] ? mq[L-1][11:0] : 12'hBAD;
      assign snap = {pix, hs, vs, act, fs, rd_en, |rd_addr};

      // Memory model: data = addr[11:0], L cycles after the strobe.
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < L; i++) mq[i] <= '0;
         end else begin
            mq[0] <= {fb.rd_en, fb.rd_addr};
            for (int i = 1; i < L; i++) mq[i] <= mq[i-1];
         end
      end

      // Scoreboard: push model state, pop L+2 cycles later.
      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
            for (int i = 0; i < L + 2; i++) q.push_back(idle_exp());
            prev = idle_exp();
            tag_valid = 1'b0;
            chk($sformatf("reset_out_L%0d", L), 32'(snap), {12'h000, 6'b110000});
         end else begin
            e = model_exp();
            q.push_back(e);
            f = q.pop_front();
            chk($sformatf("out_L%0d", L), {pix, hs, vs, act, fs},
                {f.pix, f.hs, f.vs, f.act, f.fs});
            chk($sformatf("rd_en_L%0d", L), 32'(rd_en), 32'(prev.rd_en));
            if (prev.rd_en || prev.mode)
               chk($sformatf("rd_addr_L%0d", L), 32'(rd_addr), 32'(prev.rd_addr));
            tag_valid = f.valid;
            tag_mode  = f.mode;
            tag_h     = f.h;
            tag_v     = f.v;
            prev      = e;
         end
      end
   end

   task automatic wait_model(input int h, input int v);
      logic ok;
      ok = 1'b0;
      for (int n = 0; n < 3 * FRAME && !ok; n++) begin
         @(negedge clk);
         #1;
         ok = (m_h == h) && (m_v == v);
      end
      chk("wait_model", 32'(ok), 32'd1);
   endtask

   vec_t tbl [14];
   int   n, erd, c_act, c_hs, c_vs, max_addr;
   logic ok;

   initial begin
      tbl[0]  = '{0, 2, 12'hFFF, 1, 1, 1};
      tbl[1]  = '{3, 2, 12'hFF0, 1, 1, 1};
      tbl[2]  = '{4, 2, 12'h0FF, 1, 1, 1};
      tbl[3]  = '{7, 2, 12'h0F0, 1, 1, 1};
      tbl[4]  = '{8, 2, 12'hF0F, 1, 1, 1};
      tbl[5]  = '{11, 2, 12'hF00, 1, 1, 1};
      tbl[6]  = '{12, 2, 12'h00F, 1, 1, 1};
      tbl[7]  = '{15, 2, 12'h000, 1, 1, 1};
      tbl[8]  = '{16, 2, 12'h000, 1, 1, 0};
      tbl[9]  = '{18, 2, 12'h000, 0, 1, 0};
      tbl[10] = '{20, 2, 12'h000, 0, 1, 0};
      tbl[11] = '{21, 2, 12'h000, 1, 1, 0};
      tbl[12] = '{0, 7, 12'h000, 1, 0, 0};
      tbl[13] = '{0, 9, 12'h000, 1, 1, 0};

      nchk = 0;
      fails = 0;
      rst_n = 1'b0;
      pattern_en = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      n = 0; erd = 0; ok = 1'b0;
      while (!ok && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         if (erd == 0 && lane[1].rd_en) erd = n;
         ok = lane[1].act;
      end
      chk("first_rd_edge", 32'(erd), 32'd1);
      chk("first_act_edge", 32'(n), 32'd4);
      chk("first_fs", 32'(lane[1].fs), 32'd1);
      chk("first_pix", 32'(lane[1].pix), 32'h000);
      @(posedge clk);
      #1;
      chk("second_pix", 32'(lane[1].pix), 32'h001);
      chk("second_fs", 32'(lane[1].fs), 32'd0);

      c_act = 0; c_hs = 0; c_vs = 0; max_addr = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         c_act += int'(lane[0].act);
         c_hs  += int'(!lane[0].hs);
         c_vs  += int'(!lane[0].vs);
         if (lane[0].rd_en && int'(lane[0].rd_addr) > max_addr)
            max_addr = int'(lane[0].rd_addr);
      end
      chk("frame_active", 32'(c_act), 32'(HA * VA));
      chk("frame_hsync", 32'(c_hs), 32'(HS * VT));
      chk("frame_vsync", 32'(c_vs), 32'(VS * HT));
      chk("frame_last_addr", 32'(max_addr), 32'(HA * VA - 1));

      wait_model(5, 2);
      pattern_en = 1'b1;
      for (int i = 0; i < 14; i++) begin
         ok = 1'b0;
         for (int k = 0; k < 3 * FRAME && !ok; k++) begin
            @(negedge clk);
            #1;
            ok = lane[3].tag_valid && lane[3].tag_mode &&
                 int'(lane[3].tag_h) == tbl[i].h &&
                 int'(lane[3].tag_v) == tbl[i].v;
         end
         chk($sformatf("vec%0d_found", i), 32'(ok), 32'd1);
         if (ok) begin
            chk($sformatf("vec%0d_pix", i), 32'(lane[3].pix), 32'(tbl[i].pix));
            chk($sformatf("vec%0d_sync", i), {lane[3].hs, lane[3].vs},
                {tbl[i].hs, tbl[i].vs});
            chk($sformatf("vec%0d_act", i), 32'(lane[3].act), 32'(tbl[i].act));
         end
      end

      for (int k = 0; k < 4; k++) begin
         pattern_en = ~pattern_en;
         repeat (FRAME) @(negedge clk);
      end

      pattern_en = 1'b1;
      wait_model(10, 3);
      #1 rst_n = 1'b0;
      #1;
      chk("async_rst_L1", 32'(lane[0].snap), {12'h000, 6'b110000});
      chk("async_rst_L2", 32'(lane[1].snap), {12'h000, 6'b110000});
      chk("async_rst_L3", 32'(lane[2].snap), {12'h000, 6'b110000});
      chk("async_rst_L4", 32'(lane[3].snap), {12'h000, 6'b110000});
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b1;

      n = 0; ok = 1'b0;
      while (!ok && n < 20) begin
         @(posedge clk);
         #1;
         n++;
         ok = lane[3].act;
      end
      chk("restart_act_edge", 32'(n), 32'd6);
      chk("restart_fs", 32'(lane[3].fs), 32'd1);
      chk("restart_pix0", 32'(lane[3].pix), 32'h000);
      @(posedge clk);
      #1;
      chk("restart_pix1", 32'(lane[3].pix), 32'h001);

      repeat (FRAME + 20) @(negedge clk);
      pattern_en = 1'b0;
      repeat (10) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, fails);
      $finish;
   end
endmodule
